// File: rtl/ram_tdp_arbiter_4x2.sv
// ram_tdp_arbiter_4x2: shares one true-dual-port RAM between four requesters.
// Each cycle up to two requests are granted in round-robin order: the first
// valid requester goes to port A, the second to port B, unless B would touch
// A's address with a write involved. Read data returns one cycle after grant.
// Optional build macro RAM_ARB_INIT_EN adds a post-reset sweep that zeroes the
// whole RAM (two words per cycle) before any request is accepted.
module ram_tdp_arbiter_4x2 #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req_valid,
  input  logic [3:0]          req_we,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          req_ready,
  output logic [3:0]          rsp_valid,
  output logic [4*DATA_W-1:0] rsp_rdata,
  output logic                weA,
  output logic                weB,
  output logic                reA,
  output logic                reB,
  output logic [ADDR_W-1:0]   addrA,
  output logic [ADDR_W-1:0]   addrB,
  output logic [DATA_W-1:0]   dinA,
  output logic [DATA_W-1:0]   dinB,
  input  logic [DATA_W-1:0]   doutA,
  input  logic [DATA_W-1:0]   doutB
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_reg;
  logic [1:0]          rr_ptr_reg;
  logic [1:0]          rr_ptr_next;
  logic [3:0]          rsp_pend_reg;
  logic [3:0]          rsp_pend_next;
  logic [3:0]          rsp_port_b_reg;
  logic [3:0]          rsp_port_b_next;

`ifdef RAM_ARB_INIT_EN
  logic [ADDR_W-2:0]   init_cnt_reg;
`endif

  logic [ADDR_W-1:0]   addr_arr  [4];
  logic [DATA_W-1:0]   wdata_arr [4];

  logic                a_found;
  logic                b_found;
  logic [1:0]          a_idx;
  logic [1:0]          b_idx;
  logic [1:0]          scan_idx;
  logic                conflict;
  logic                run_active;
  logic                grant_a;
  logic                grant_b;

  // Unpack the flat request buses into per-requester views.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan requesters starting at rr_ptr; first valid -> A candidate, second -> B candidate.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = 2'd0;
    b_idx    = 2'd0;
    scan_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_reg + 2'(k);
      if (req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
    end
  end

  // A same-address pair is only safe when both sides read.
  assign conflict   = (addr_arr[b_idx] == addr_arr[a_idx]) && (req_we[a_idx] || req_we[b_idx]);
  assign run_active = !rst && (state_reg == ST_RUN);
  assign grant_a    = run_active && a_found;
  assign grant_b    = run_active && b_found && !conflict;

  // Grant vector and next round-robin pointer (one past the last granted index).
  always_comb begin
    req_ready   = 4'b0000;
    rr_ptr_next = rr_ptr_reg;
    if (grant_a) begin
      req_ready[a_idx] = 1'b1;
      rr_ptr_next      = a_idx + 2'd1;
    end
    if (grant_b) begin
      req_ready[b_idx] = 1'b1;
      rr_ptr_next      = b_idx + 2'd1;
    end
  end

  // RAM port drive: granted request in RUN, zero-fill sweep in INIT, idle otherwise.
  always_comb begin
    weA   = 1'b0;
    reA   = 1'b0;
    addrA = '0;
    dinA  = '0;
    weB   = 1'b0;
    reB   = 1'b0;
    addrB = '0;
    dinB  = '0;
    if (grant_a) begin
      weA   = req_we[a_idx];
      reA   = ~req_we[a_idx];
      addrA = addr_arr[a_idx];
      dinA  = wdata_arr[a_idx];
    end
    if (grant_b) begin
      weB   = req_we[b_idx];
      reB   = ~req_we[b_idx];
      addrB = addr_arr[b_idx];
      dinB  = wdata_arr[b_idx];
    end
`ifdef RAM_ARB_INIT_EN
    if (!rst && (state_reg == ST_INIT)) begin
      weA   = 1'b1;
      addrA = {init_cnt_reg, 1'b0};
      weB   = 1'b1;
      addrB = {init_cnt_reg, 1'b1};
    end
`endif
  end

  // Remember which requesters have a read in flight and which port carries it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      assign rsp_pend_next[gi]   = (grant_a && (a_idx == 2'(gi)) && !req_we[gi]) ||
                                   (grant_b && (b_idx == 2'(gi)) && !req_we[gi]);
      assign rsp_port_b_next[gi] = grant_b && (b_idx == 2'(gi));
    end
  endgenerate

  // Control state: pointer, in-flight reads, and the optional INIT sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg     <= 2'd0;
      rsp_pend_reg   <= 4'b0000;
      rsp_port_b_reg <= 4'b0000;
`ifdef RAM_ARB_INIT_EN
      state_reg      <= ST_INIT;
      init_cnt_reg   <= '0;
`else
      state_reg      <= ST_RUN;
`endif
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      rsp_pend_reg   <= rsp_pend_next;
      rsp_port_b_reg <= rsp_port_b_next;
`ifdef RAM_ARB_INIT_EN
      if (state_reg == ST_INIT) begin
        init_cnt_reg <= init_cnt_reg + 1'b1;
        if (&init_cnt_reg) begin
          state_reg <= ST_RUN;
        end
      end
`endif
    end
  end

  // Route RAM read data back to the requester; zero whenever not valid.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rsp
      assign rsp_valid[gi] = rsp_pend_reg[gi] & ~rst;
      assign rsp_rdata[gi*DATA_W +: DATA_W] = !rsp_valid[gi] ? '0 :
                                              (rsp_port_b_reg[gi] ? doutB : doutA);
    end
  endgenerate

endmodule

// File: tb/tb_ram_tdp_arbiter_4x2.sv
// Directed bench for ram_tdp_arbiter_4x2 with a behavioural dual-port RAM.
// Unwritten RAM words read back as 0xA0000000 | address.
module tb_ram_tdp_arbiter_4x2;
    localparam int AW = 9;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_we;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_wdata;
    logic [3:0]      req_ready;
    logic [3:0]      rsp_valid;
    logic [4*DW-1:0] rsp_rdata;
    logic            weA, weB, reA, reB;
    logic [AW-1:0]   addrA, addrB;
    logic [DW-1:0]   dinA, dinB;
    logic [DW-1:0]   doutA, doutB;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [DW-1:0]   mem [512];
    logic [511:0]    wr_flag;
    logic            mem_clear;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always #5 clk = ~clk;

    ram_tdp_arbiter_4x2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .weA(weA), .weB(weB), .reA(reA), .reB(reB),
        .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
        .doutA(doutA), .doutB(doutB)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hA000_0000 | {23'd0, a};
    endfunction

    // Behavioural RAM: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (mem_clear) begin
            wr_flag <= '0;
        end else begin
            if (weA) begin mem[addrA] <= dinA; wr_flag[addrA] <= 1'b1; end
            if (weB) begin mem[addrB] <= dinB; wr_flag[addrB] <= 1'b1; end
        end
        if (reA) doutA <= wr_flag[addrA] ? mem[addrA] : pat(addrA);
        if (reB) doutB <= wr_flag[addrB] ? mem[addrB] : pat(addrB);
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic tick(input string name);
        $display("step %0s: req_valid=%b req_ready=%b rsp_valid=%b", name, req_valid, req_ready, rsp_valid);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mem_clear = 1'b1;
        req_valid = 4'b0000; req_we = 4'b0000; req_addr = '0; req_wdata = '0;
        set_req(0, 1'b0, 9'h010, 32'h0);
        set_req(1, 1'b0, 9'h020, 32'h0);
        set_req(2, 1'b0, 9'h030, 32'h0);
        set_req(3, 1'b0, 9'h040, 32'h0);
        @(negedge clk);

        // Reset cycle with all requesters active: nothing may be granted.
        req_valid = 4'b1111;
        #1;
        check("rst_ready", req_ready, 4'b0000);
        check("rst_reA", reA, 1'b0);
        check("rst_reB", reB, 1'b0);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        tick("reset");
        rst = 1'b0; mem_clear = 1'b0; req_valid = 4'b0000;
        #1;
        check("post_rst_rsp_valid", rsp_valid, 4'b0000);
        check("post_rst_rsp_rdata", rsp_rdata, 128'h0);

`ifdef RAM_ARB_INIT_EN
        // Sweep interrupted at cycle 100, then a full 256-cycle sweep.
        req_valid = 4'b1111;
        for (int c = 0; c < 100; c++) begin
            #1;
            check("init_ready", req_ready, 4'b0000);
            check("init_addrA", addrA, 9'(2*c));
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        tick("init_rst");
        rst = 1'b0;
        for (int c = 0; c < 256; c++) begin
            #1;
            check("init2_ready", req_ready, 4'b0000);
            check("init2_addrB", addrB, 9'(2*c+1));
            @(posedge clk); @(negedge clk);
        end
        req_valid = 4'b0011;
        set_req(0, 1'b0, 9'h000, 32'h0);
        set_req(1, 1'b0, 9'h1FF, 32'h0);
        #1;
        check("init_done_ready", req_ready, 4'b0011);
        tick("init_read");
        req_valid = 4'b0000;
        #1;
        check("init_rd0", rsp_rdata[0*DW +: DW], 32'h0);
        check("init_rd1ff", rsp_rdata[1*DW +: DW], 32'h0);
        mem_clear = 1'b1;
        rst = 1'b1;
        tick("reinit");
        rst = 1'b0; mem_clear = 1'b0;
        repeat (256) @(negedge clk);
        set_req(0, 1'b0, 9'h010, 32'h0);
        set_req(1, 1'b0, 9'h020, 32'h0);
`endif

        // Four reads, pointer 0: grants 0(A),1(B) then 2(A),3(B).
        req_valid = 4'b1111;
        #1;
        check("t1_ready", req_ready, 4'b0011);
        check("t1_addrA", addrA, 9'h010);
        check("t1_addrB", addrB, 9'h020);
        check("t1_reA_reB", {reA, reB, weA, weB}, 4'b1100);
        tick("four_reads_1");
        req_valid = 4'b1100;
        #1;
        check("t2_rsp_valid", rsp_valid, 4'b0011);
        check("t2_rd0", rsp_rdata[0*DW +: DW], 32'hA000_0010);
        check("t2_rd1", rsp_rdata[1*DW +: DW], 32'hA000_0020);
        check("t2_ready", req_ready, 4'b1100);
        check("t2_addrA", addrA, 9'h030);
        check("t2_addrB", addrB, 9'h040);
        tick("four_reads_2");

        // Write/read collision on 0x1FF: only the writer goes.
        req_valid = 4'b0011;
        set_req(0, 1'b1, 9'h1FF, 32'hDEAD_BEEF);
        set_req(1, 1'b0, 9'h1FF, 32'h0);
        #1;
        check("t3_rsp_valid", rsp_valid, 4'b1100);
        check("t3_rd2", rsp_rdata[2*DW +: DW], 32'hA000_0030);
        check("t3_rd3", rsp_rdata[3*DW +: DW], 32'hA000_0040);
        check("t3_ready", req_ready, 4'b0001);
        check("t3_weA", {weA, reA}, 2'b10);
        check("t3_dinA", dinA, 32'hDEAD_BEEF);
        check("t3_portB_idle", {weB, reB, addrB, dinB}, 43'h0);
        tick("collide_write");
        req_valid = 4'b0010;
        #1;
        check("t4_rsp_valid", rsp_valid, 4'b0000);
        check("t4_ready", req_ready, 4'b0010);
        check("t4_portA", {reA, addrA}, {1'b1, 9'h1FF});
        tick("collide_read");

        // Two reads of the same address in one cycle.
        req_valid = 4'b1100;
        set_req(2, 1'b0, 9'h100, 32'h0);
        set_req(3, 1'b0, 9'h100, 32'h0);
        #1;
        check("t5_rsp_valid", rsp_valid, 4'b0010);
        check("t5_rd1", rsp_rdata[1*DW +: DW], 32'hDEAD_BEEF);
        check("t5_ready", req_ready, 4'b1100);
        check("t5_reAB", {reA, reB, addrA, addrB}, {2'b11, 9'h100, 9'h100});
        tick("same_addr_reads");

        // Read on A, write on B to the same address: B blocked.
        req_valid = 4'b0011;
        set_req(0, 1'b0, 9'h0AA, 32'h0);
        set_req(1, 1'b1, 9'h0AA, 32'h1234_5678);
        #1;
        check("t6_rsp_valid", rsp_valid, 4'b1100);
        check("t6_rd2", rsp_rdata[2*DW +: DW], 32'hA000_0100);
        check("t6_rd3", rsp_rdata[3*DW +: DW], 32'hA000_0100);
        check("t6_ready", req_ready, 4'b0001);
        tick("read_vs_write");

        // Lone requester 3, three cycles in a row, always on port A.
        req_valid = 4'b1000;
        set_req(3, 1'b0, 9'h055, 32'h0);
        #1;
        check("t7_rsp_valid", rsp_valid, 4'b0001);
        check("t7_rd0", rsp_rdata[0*DW +: DW], 32'hA000_00AA);
        for (int r = 0; r < 3; r++) begin
            if (r > 0) begin
                #1;
                check("t8_rsp_valid", rsp_valid, 4'b1000);
                check("t8_rd3", rsp_rdata[3*DW +: DW], 32'hA000_0055);
            end
            check("t8_ready", req_ready, 4'b1000);
            check("t8_portA", {reA, reB, addrA}, {2'b10, 9'h055});
            tick("lone_req3");
        end

        // All four again: pointer must be back at 0 after the lone grants.
        req_valid = 4'b1111;
        set_req(0, 1'b0, 9'h010, 32'h0);
        set_req(1, 1'b0, 9'h020, 32'h0);
        set_req(2, 1'b0, 9'h030, 32'h0);
        set_req(3, 1'b0, 9'h040, 32'h0);
        #1;
        check("t10_rsp_valid", rsp_valid, 4'b1000);
        check("t10_ready", req_ready, 4'b0011);
        tick("ptr_check");

        // Read grant to 1 (pointer now 2), then reset the next cycle.
        req_valid = 4'b0010;
        #1;
        check("t11_rsp_valid", rsp_valid, 4'b0011);
        check("t11_ready", req_ready, 4'b0010);
        tick("read_before_rst");
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        check("t12_rsp_valid", rsp_valid, 4'b0000);
        check("t12_rsp_rdata", rsp_rdata, 128'h0);
        check("t12_ready", req_ready, 4'b0000);
        check("t12_ctrl", {weA, reA, weB, reB, addrA, addrB}, 22'h0);
        tick("rst_mid");
        rst = 1'b0; req_valid = 4'b0000;
        #1;
        check("t13_rsp_valid", rsp_valid, 4'b0000);
        check("t13_rsp_rdata", rsp_rdata, 128'h0);
        check("t13_ready", req_ready, 4'b0000);
`ifndef RAM_ARB_INIT_EN
        check("t13_ctrl", {weA, reA, weB, reB}, 4'b0000);
`endif
        tick("after_rst");
`ifdef RAM_ARB_INIT_EN
        repeat (255) @(negedge clk);
`endif

        // Pointer reset to 0: all four valid grants 0 and 1.
        req_valid = 4'b1111;
        #1;
        check("t14_ready", req_ready, 4'b0011);
        tick("ptr_after_rst");
        req_valid = 4'b0000;
        #1;
        check("t15_rsp_valid", rsp_valid, 4'b0011);
`ifndef RAM_ARB_INIT_EN
        check("t15_rd1", rsp_rdata[1*DW +: DW], 32'hA000_0020);
`endif
        tick("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_tdp_arbiter_4x2.md
RAM_TDP_ARBITER_4X2 -- requirements
Module: ram_tdp_arbiter_4x2

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM word-address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have port clk, input, 1, single clock for all logic; rising edge active.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 4, per-requester request valid.
REQ-006 SHALL have port req_we, input, 4, per-requester write (1) / read (0).
REQ-007 SHALL have port req_addr, input, 4*ADDR_W, requester i at slice [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_wdata, input, 4*DATA_W, requester i at slice [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_ready, output, 4, grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-010 SHALL have port rsp_valid, output, 4, read-data valid per requester.
REQ-011 SHALL have port rsp_rdata, output, 4*DATA_W, read data per requester; 0 when rsp_valid[i] is low.
REQ-012 SHALL have ports weA, weB, reA, reB (output, 1), addrA, addrB (output, ADDR_W), dinA, dinB (output, DATA_W): RAM port controls.
REQ-013 SHALL have ports doutA, doutB, input, DATA_W, RAM read data, valid one cycle after reX asserted.

Function
REQ-014 SHALL grant at most two requests per cycle: first valid requester in round-robin order from rr_ptr to port A, second to port B.
REQ-015 SHALL compute req_ready combinationally from req_valid, req_we, req_addr, rr_ptr and state; req_ready[i] never high when req_valid[i] low.
REQ-016 SHALL NOT grant the port-B candidate when its address equals the port-A address and either request is a write; it stays pending, waiting for a later cycle.
REQ-017 SHALL allow two reads of the same address in one cycle.
REQ-018 SHALL drive weX=req_we, reX=~req_we, addrX, dinX of the granted requester in the grant cycle; idle port drives weX=reX=0, addr=0, din=0.
REQ-019 SHALL assert rsp_valid[i] exactly one cycle after a read grant to i, with rsp_rdata slice i = doutA or doutB of the port used.
REQ-020 SHALL advance rr_ptr to (last granted index + 1) mod 4 after any grant; unchanged when nothing granted.
REQ-021 SHALL give no response for writes; write completes in the grant cycle.
REQ-022 SHALL have states INIT and RUN; INIT exists only per REQ-027, otherwise the block resets directly into RUN.

Reset
REQ-023 SHALL on rst: rr_ptr=0, rsp_valid=0, rsp_rdata=0, all RAM controls 0, req_ready=0 during the reset cycle.
REQ-024 SHALL discard any read response in flight when rst asserts; no rsp_valid in the cycle after reset.
REQ-025 SHALL restart INIT from address 0 if rst asserts mid-INIT.

Configuration
REQ-026 SHALL use macro RAM_ARB_INIT_EN to compile the initialisation sweep in or out.
REQ-027 SHALL with RAM_ARB_INIT_EN defined: after reset enter INIT, write 0 to addresses 2k via port A and 2k+1 via port B for k=0..2^(ADDR_W-1)-1 (256 cycles at default), hold req_ready=0, then enter RUN.
REQ-028 SHALL without RAM_ARB_INIT_EN: enter RUN the first cycle after reset; RAM contents untouched.

Verification
REQ-029 SHALL cover: all four req_valid=1, reads to addresses 0x010/0x020/0x030/0x040, rr_ptr=0 -> cycle1 grants 0(A),1(B), cycle2 grants 2(A),3(B); rsp_valid one cycle after each grant.
REQ-030 SHALL cover: requester 0 write 0xDEADBEEF to 0x1FF, requester 1 read 0x1FF same cycle -> only req 0 granted; req 1 granted next cycle, rsp_rdata=0xDEADBEEF.
REQ-031 SHALL cover: requesters 2 and 3 both read 0x100 -> both granted same cycle, identical rsp_rdata.
REQ-032 SHALL cover: only requester 3 valid repeatedly -> granted every cycle on port A, rr_ptr stays 0 after each grant.
REQ-033 SHALL cover: with RAM_ARB_INIT_EN, req_ready=0 for 256 cycles after reset, then reads of 0x000 and 0x1FF return 0; rst at cycle 100 restarts sweep.
REQ-034 SHALL cover: rst asserted in cycle after a read grant -> no rsp_valid, all outputs 0 next cycle.
